// File: rtl/wb_slave_burst_ram_if.sv
// Wishbone B3 signal bundle between a tile bus master and wb_slave_burst_ram.
// Directions are named from the bus, not from either endpoint.
interface wb_slave_burst_ram_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat_w;
    logic [DATA_WIDTH-1:0] dat_r;
    logic [3:0]            sel;
    logic                  we;
    logic                  cyc;
    logic                  stb;
    logic [2:0]            cti;
    logic [1:0]            bte;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_slave_burst_ram.sv
// Wishbone B3 single-port RAM slave with programmable wait states.
// Define WB_SLAVE_BURST_EN for registered-feedback linear/wrap-4/8/16 bursts.
module wb_slave_burst_ram #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    wb_slave_burst_ram_if.slave wb
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
`ifdef WB_SLAVE_BURST_EN
        ST_ACK,
        ST_BURST
`else
        ST_ACK
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      rd_idx;
    logic                  load_dat;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic             req;
    logic             aligned;
    logic [IDX_W-1:0] adr_idx;
    logic             miss;
    logic             commit;
    logic             unused_in;

    assign req     = wb.cyc & wb.stb;
    assign aligned = (wb.adr[1:0] == 2'b00);
    assign adr_idx = wb.adr[IDX_W+1:2];

`ifdef WB_SLAVE_BURST_EN
    // Burst beats present a pre-registered ack; a beat whose address
    // disagrees with the prediction must not see it.
    assign miss      = (state_q == ST_BURST) && (adr_idx != idx_q);
    assign unused_in = ^wb.adr[ADDR_WIDTH-1:IDX_W+2];

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur,
                                                  input logic [1:0]       bte);
        logic [IDX_W-1:0] inc;
        logic [IDX_W-1:0] mask;
        inc = cur + IDX_W'(1);
        case (bte)
            2'b01:   mask = IDX_W'(3);
            2'b10:   mask = IDX_W'(7);
            2'b11:   mask = IDX_W'(15);
            default: mask = '1;
        endcase
        return (cur & ~mask) | (inc & mask);
    endfunction
`else
    assign miss      = 1'b0;
    assign unused_in = ^{wb.adr[ADDR_WIDTH-1:IDX_W+2], wb.cti, wb.bte};
`endif

    assign wb.ack   = ack_q & req & ~miss;
    assign wb.err   = err_q & req;
    assign wb.rty   = 1'b0;
    assign wb.dat_r = dat_q;
    assign commit   = wb.ack & wb.we;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        idx_d    = idx_q;
        rd_idx   = idx_q;
        load_dat = 1'b0;
        if (!wb.cyc) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wb.stb) begin
                        idx_d  = adr_idx;
                        rd_idx = adr_idx;
                        if (!aligned) begin
                            err_d   = 1'b1;
                            state_d = ST_ACK;
                        end else if (WAIT_STATES == 0) begin
                            ack_d    = 1'b1;
                            load_dat = 1'b1;
                            state_d  = ST_ACK;
                        end else begin
                            cnt_d   = WS_INIT;
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wb.stb) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q <= 4'd1) begin
                        cnt_d    = '0;
                        ack_d    = 1'b1;
                        load_dat = 1'b1;
                        state_d  = ST_ACK;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_d = ST_IDLE;
`ifdef WB_SLAVE_BURST_EN
                    if (wb.stb && ack_q && wb.cti == 3'b010) begin
                        idx_d    = next_idx(idx_q, wb.bte);
                        rd_idx   = idx_d;
                        ack_d    = 1'b1;
                        load_dat = 1'b1;
                        state_d  = ST_BURST;
                    end
`endif
                end
`ifdef WB_SLAVE_BURST_EN
                ST_BURST: begin
                    // ack_q stays up as "beat ready"; a master wait holds it
                    ack_d = 1'b1;
                    if (wb.stb) begin
                        if (miss) begin
                            ack_d   = 1'b0;
                            err_d   = 1'b1;
                            state_d = ST_ACK;
                        end else if (wb.cti != 3'b010) begin
                            ack_d   = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d    = next_idx(idx_q, wb.bte);
                            rd_idx   = idx_d;
                            load_dat = 1'b1;
                        end
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            if (load_dat) begin
                dat_q <= mem[rd_idx];
            end
        end
    end

    // Writes land only on an edge where the master actually sees ack.
    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wb.sel[b]) begin
                    mem[idx_q][8*b +: 8] <= wb.dat_w[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_slave_burst_ram.sv
// Randomized bench for wb_slave_burst_ram against a word-array reference model;
// expected latencies follow WB_SLAVE_BURST_EN when it is defined.
`timescale 1ns/1ps
module tb_wb_slave_burst_ram;
    localparam int unsigned MEM_WORDS   = 64;
    localparam int unsigned WAIT_STATES = 2;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] ref_mem [MEM_WORDS];

    wb_slave_burst_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

    wb_slave_burst_ram #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_WORDS(MEM_WORDS),
        .WAIT_STATES(WAIT_STATES)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .wb(wb)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] m;
        m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    // Wrap-N keeps the aligned N-word block and cycles inside it.
    function automatic int unsigned next_word(input int unsigned w, input logic [1:0] bte);
        int unsigned n;
        case (bte)
            2'b01:   n = 4;
            2'b10:   n = 8;
            2'b11:   n = 16;
            default: n = 0;
        endcase
        if (n == 0) return (w + 1) % MEM_WORDS;
        return (w / n) * n + ((w % n) + 1) % n;
    endfunction

    task automatic bus_idle();
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.sel = '0;
        wb.cti = 3'b000; wb.bte = 2'b00; wb.adr = '0; wb.dat_w = '0;
    endtask

    task automatic drive(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.adr = adr; wb.we = we;
        wb.dat_w = dat; wb.sel = sel; wb.cti = cti; wb.bte = bte;
    endtask

    // Called at posedge+1 with a request driven; returns at the negedge
    // where ack/err is seen (or after the budget, leaving lat large).
    task automatic wait_resp(output int lat, output logic a, output logic e, output logic [31:0] rd);
        bit done;
        lat = 0; a = 1'b0; e = 1'b0; rd = '0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk_i);
            lat++;
            if (wb.ack || wb.err) begin
                a = wb.ack; e = wb.err; rd = wb.dat_r; done = 1;
            end else begin
                @(posedge clk_i); #1;
            end
        end
    endtask

    task automatic classic(input string tag, input logic [31:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel, output logic [31:0] rdata);
        int          lat;
        logic        a, e, mis;
        int unsigned w;
        w   = (adr >> 2) % MEM_WORDS;
        mis = (adr[1:0] != 2'b00);
        drive(adr, we, dat, sel, 3'b000, 2'b00);
        wait_resp(lat, a, e, rdata);
        check_eq({tag, ".lat"}, lat, mis ? 32'd2 : 32'(WAIT_STATES + 2));
        check_eq({tag, ".ack"}, 32'(a), 32'(!mis));
        check_eq({tag, ".err"}, 32'(e), 32'(mis));
        if (!mis && !we) check_eq({tag, ".dat"}, rdata, ref_mem[w]);
        @(posedge clk_i); #1;
        if (!mis && we) ref_mem[w] = merge(ref_mem[w], dat, sel);
        bus_idle();
    endtask

    task automatic burst(input string tag, input int unsigned start, input logic [1:0] bte,
                         input int len, input logic we, input int gap_after, input int bad_beat);
        int unsigned w;
        w = start;
        for (int k = 0; k < len; k++) begin
            int          lat, exp_lat;
            logic        a, e, exp_err;
            logic [31:0] rd, dat;
            logic [3:0]  sel;
            int unsigned aw;
            aw  = (k == bad_beat) ? (w + 5) % MEM_WORDS : w;
            dat = $urandom;
            sel = 4'($urandom_range(1, 15));
            drive(32'(aw << 2), we, dat, sel, (k == len - 1) ? 3'b111 : 3'b010, bte);
            wait_resp(lat, a, e, rd);
`ifdef WB_SLAVE_BURST_EN
            exp_err = (k == bad_beat);
            exp_lat = (k == 0) ? WAIT_STATES + 2 : (exp_err ? 2 : 1);
`else
            exp_err = 1'b0;
            exp_lat = WAIT_STATES + 2;
`endif
            check_eq({tag, ".lat"}, lat, exp_lat);
            check_eq({tag, ".ack"}, 32'(a), 32'(!exp_err));
            check_eq({tag, ".err"}, 32'(e), 32'(exp_err));
            if (!exp_err && !we) check_eq({tag, ".dat"}, rd, ref_mem[aw]);
            @(posedge clk_i); #1;
            if (!exp_err && we) ref_mem[aw] = merge(ref_mem[aw], dat, sel);
            if (k == gap_after && k < len - 1) begin
                wb.stb = 1'b0;
                repeat (2) begin
                    @(negedge clk_i);
                    check_eq({tag, ".gap_ack"}, 32'(wb.ack), 32'd0);
                    @(posedge clk_i); #1;
                end
            end
            w = next_word(w, bte);
        end
        bus_idle();
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        a, e;

        rst_ni = 1'b0;
        bus_idle();
        #1;
        check_eq("rst.ack", 32'(wb.ack), 32'd0);
        check_eq("rst.err", 32'(wb.err), 32'd0);
        check_eq("rst.rty", 32'(wb.rty), 32'd0);
        check_eq("rst.dat", wb.dat_r, 32'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < MEM_WORDS; i++) begin
            ref_mem[i] = '0;
            classic("fill", 32'(i * 4), 1'b1, $urandom, 4'hF, rd);
        end

        classic("wr_beef", 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd);
        classic("rd_beef", 32'h10, 1'b0, '0, 4'hF, rd);
        check_eq("beef_val", rd, 32'hDEADBEEF);
        classic("wr_sel", 32'h10, 1'b1, 32'h0000AA00, 4'b0010, rd);
        classic("rd_sel", 32'h10, 1'b0, '0, 4'hF, rd);
        check_eq("sel_val", rd, 32'hDEADAAEF);

        burst("wrap4_rd", 6, 2'b01, 4, 1'b0, -1, -1);
        burst("lin_wrap_rd", MEM_WORDS - 2, 2'b00, 4, 1'b0, -1, -1);
        burst("lin_wrap_wr", MEM_WORDS - 3, 2'b00, 5, 1'b1, -1, -1);
        burst("lin_wrap_chk", MEM_WORDS - 3, 2'b00, 5, 1'b0, -1, -1);
        burst("gap_wr", 20, 2'b10, 6, 1'b1, 2, -1);
        burst("gap_rd", 20, 2'b10, 6, 1'b0, 2, -1);
        burst("mismatch", 40, 2'b00, 3, 1'b1, -1, 2);
        classic("post_mis", 32'(47 * 4), 1'b0, '0, 4'hF, rd);

        classic("misalign", 32'h13, 1'b1, 32'h11223344, 4'hF, rd);
        classic("misalign_rd", 32'h10, 1'b0, '0, 4'hF, rd);
        check_eq("misalign_keep", rd, 32'hDEADAAEF);

        drive(32'h24, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, 2'b00);
        @(negedge clk_i);
        check_eq("cycdrop.ack0", 32'(wb.ack), 32'd0);
        @(posedge clk_i); #1;
        bus_idle();
        repeat (4) begin
            @(negedge clk_i);
            check_eq("cycdrop.ack", 32'(wb.ack), 32'd0);
            check_eq("cycdrop.err", 32'(wb.err), 32'd0);
            @(posedge clk_i); #1;
        end
        classic("cycdrop_rd", 32'h24, 1'b0, '0, 4'hF, rd);

        drive(32'h20, 1'b1, 32'h12345678, 4'hF, 3'b000, 2'b00);
        wait_resp(lat, a, e, rd);
        check_eq("rstmid.ack_seen", 32'(a), 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        check_eq("rstmid.ack", 32'(wb.ack), 32'd0);
        check_eq("rstmid.dat", wb.dat_r, 32'd0);
        @(posedge clk_i); #1;
        bus_idle();
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        classic("rstmid_rd", 32'h20, 1'b0, '0, 4'hF, rd);

        for (int it = 0; it < 30; it++) begin
            int unsigned kind, len;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                logic [31:0] adr;
                adr = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
                if ($urandom_range(0, 3) == 0) adr[1:0] = 2'($urandom_range(1, 3));
                classic("rnd_cl", adr, 1'($urandom), $urandom, 4'($urandom_range(1, 15)), rd);
            end else begin
                len = $urandom_range(1, 8);
                burst("rnd_bu", $urandom_range(0, MEM_WORDS - 1), 2'($urandom), int'(len),
                      1'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1, -1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            int unsigned w;
            w = $urandom_range(0, MEM_WORDS - 1);
            classic("final_rd", 32'(w * 4), 1'b0, '0, 4'hF, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
